serial_leading_one_detector: RTL and testbench

//  Parametrised, handshaked leading-one detector/normaliser for the serial quantizer datapath.

---
 rtl/serial_leading_one_detector.sv | 126 ++++++++++++
 tb/tb_serial_leading_one_detector.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_leading_one_detector.sv
// Serial leading-one detector / normaliser.
// Scans a word MSB-first, CHUNK bits per cycle, over a valid/ready handshake.
module serial_leading_one_detector #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int POS_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_pos,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic             busy
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int LZW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

  if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("WIDTH must be a nonzero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_scan;
  logic [KW-1:0]    r_k;
  logic [POS_W-1:0] r_pos;
  logic             r_zero;
  logic [WIDTH-1:0] r_norm;

  logic [CHUNK-1:0] w_chunk;
  logic             w_hit;
  logic [LZW-1:0]   w_lz;
  logic             w_last;
  logic [POS_W-1:0] w_pos;
  logic [WIDTH-1:0] w_norm;
  logic             w_accept;
  logic             w_retire;

  // r_scan holds the captured word pre-shifted by k*CHUNK,
  // so the chunk under test is always at the top.
  assign w_chunk  = r_scan[WIDTH-1 -: CHUNK];
  assign w_last   = (r_k == KW'(NCH-1));
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_retire = (r_state == DONE) && out_ready;

  always_comb begin
    w_hit = 1'b0;
    w_lz  = '0;
    for (int i = CHUNK-1; i >= 0; i--) begin
      if (!w_hit && w_chunk[i]) begin
        w_hit = 1'b1;
        w_lz  = LZW'(CHUNK-1-i);
      end
    end
  end

  assign w_pos  = POS_W'(WIDTH - int'(r_k)*CHUNK - int'(w_lz));
  assign w_norm = r_scan << w_lz;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next = SCAN;
      SCAN: if (w_hit || w_last) w_next = DONE;
      DONE: if (w_retire) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scan <= '0;
      r_k    <= '0;
      r_pos  <= '0;
      r_zero <= 1'b0;
      r_norm <= '0;
    end else begin
      if (w_accept) begin
        r_scan <= in_word;
        r_k    <= '0;
      end else if (r_state == SCAN) begin
        if (w_hit) begin
          r_pos  <= w_pos;
          r_zero <= 1'b0;
          r_norm <= w_norm;
        end else if (w_last) begin
          r_pos  <= '0;
          r_zero <= 1'b1;
          r_norm <= '0;
        end else begin
          r_k    <= r_k + KW'(1);
          r_scan <= r_scan << CHUNK;
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = (r_state == DONE);
  assign out_pos   = r_pos;
  assign out_zero  = r_zero;
  assign out_norm  = r_norm;

endmodule

// File: tb/tb_serial_leading_one_detector.sv
// Directed and random checks for serial_leading_one_detector.
// Instance 0 uses CHUNK=8, instance 1 uses CHUNK=32.
module tb_serial_leading_one_detector;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sel;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_word;

  logic        rdy0, ov0, z0, b0;
  logic [5:0]  p0;
  logic [31:0] n0;
  logic        rdy1, ov1, z1, b1;
  logic [5:0]  p1;
  logic [31:0] n1;

  serial_leading_one_detector #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & ~sel), .in_ready(rdy0), .in_word(in_word),
    .out_valid(ov0), .out_ready(out_ready & ~sel),
    .out_pos(p0), .out_zero(z0), .out_norm(n0), .busy(b0)
  );

  serial_leading_one_detector #(.WIDTH(32), .CHUNK(32)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid & sel), .in_ready(rdy1), .in_word(in_word),
    .out_valid(ov1), .out_ready(out_ready & sel),
    .out_pos(p1), .out_zero(z1), .out_norm(n1), .busy(b1)
  );

  logic        m_valid, m_ready, m_zero, m_busy;
  logic [5:0]  m_pos;
  logic [31:0] m_norm;
  assign m_valid = sel ? ov1 : ov0;
  assign m_ready = sel ? rdy1 : rdy0;
  assign m_zero  = sel ? z1 : z0;
  assign m_busy  = sel ? b1 : b0;
  assign m_pos   = sel ? p1 : p0;
  assign m_norm  = sel ? n1 : n0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called #1 after a posedge with the DUT idle.
  task automatic run(input logic [31:0] w, input int epos,
                     input logic ezero, input logic [31:0] enorm,
                     input int elat, input bit retire, input string nm);
    int lat;
    lat = 0;
    in_word  = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_word  = ~w;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (m_valid) lat = n;
    end
    chk({nm, ".lat"}, lat, elat);
    chk({nm, ".pos"}, {26'd0, m_pos}, epos);
    chk({nm, ".zero"}, {31'd0, m_zero}, {31'd0, ezero});
    chk({nm, ".norm"}, m_norm, enorm);
    if (retire) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, ".ret"}, {m_valid, m_ready, m_busy}, 3'b010);
    end
  endtask

  typedef struct {
    logic [31:0] word;
    int          pos;
    logic        zero;
    logic [31:0] norm;
    int          lat;
  } vec_t;

  vec_t vt[10];

  int          rp;
  logic [31:0] rw, rn;

  initial begin
    vt[0] = '{32'h8000_0000, 32, 1'b0, 32'h8000_0000, 1};
    vt[1] = '{32'h0001_2345, 17, 1'b0, 32'h91A2_8000, 2};
    vt[2] = '{32'h0000_0001,  1, 1'b0, 32'h8000_0000, 4};
    vt[3] = '{32'h0000_0000,  0, 1'b1, 32'h0000_0000, 4};
    vt[4] = '{32'h00FF_FFFF, 24, 1'b0, 32'hFFFF_FF00, 2};
    vt[5] = '{32'h0000_F000, 16, 1'b0, 32'hF000_0000, 3};
    vt[6] = '{32'h7FFF_FFFF, 31, 1'b0, 32'hFFFF_FFFE, 1};
    vt[7] = '{32'h0000_0080,  8, 1'b0, 32'h8000_0000, 4};
    vt[8] = '{32'h0000_0100,  9, 1'b0, 32'h8000_0000, 3};
    vt[9] = '{32'h4000_0001, 31, 1'b0, 32'h8000_0002, 1};

    rst = 1'b0; sel = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; in_word = '0;
    #1;
    chk("rst.out", {ov0, z0, b0, p0, n0}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst.rdy", {rdy0, b0}, 2'b10);

    for (int i = 0; i < 10; i++)
      run(vt[i].word, vt[i].pos, vt[i].zero, vt[i].norm,
          vt[i].lat, 1'b1, $sformatf("v%0d", i));

    // Backpressure: result must hold, new word must be refused.
    run(32'h0040_0000, 23, 1'b0, 32'h8000_0000, 2, 1'b0, "bp");
    in_word  = 32'hFFFF_FFFF;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp.hold", {ov0, rdy0, z0, 26'd0, p0}, {3'b100, 26'd0, 6'd23});
      chk("bp.norm", n0, 32'h8000_0000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp.ret", {ov0, rdy0, b0, p0}, {3'b010, 6'd23});
    run(32'h0000_0010, 5, 1'b0, 32'h8000_0000, 4, 1'b1, "bp.next");

    // Abort by reset mid-scan.
    in_word  = 32'h0000_00F0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ab.busy", {b0, ov0}, 2'b10);
    rst = 1'b0;
    #1;
    chk("ab.out", {ov0, z0, b0, p0, n0}, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("ab.idle", {ov0, rdy0, b0}, 3'b010);
    end
    run(32'h0000_0010, 5, 1'b0, 32'h8000_0000, 4, 1'b1, "ab.next");

    // Single-cycle configuration against a reference encoder.
    sel = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10000; i++) begin
      rw = $urandom >> $urandom_range(0, 31);
      if (i % 97 == 0) rw = '0;
      rp = 0;
      for (int b = 31; b >= 0; b--)
        if (rp == 0 && rw[b]) rp = b + 1;
      rn = (rp == 0) ? 32'd0 : (rw << (32 - rp));
      run(rw, rp, (rp == 0), rn, 1, 1'b1, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
